// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the CPU datapath.
// Handshakes with imem, dmem and multiplier; sticky FAULT on timeout.
module instr_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [3:0]       OP,
    input  logic             jump,
    input  logic             branch,
    input  logic             WriteMem,
    input  logic             WriteReg,
    input  logic             MemToReg,
    input  logic             WrFlag,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             mul_done,
    output logic             imem_req,
    output logic             ir_load,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             mul_start,
    output logic             reg_we,
    output logic             flag_we,
    output logic             pc_load,
    output logic [1:0]       pc_sel,
    output logic             busy,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd7;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic [TO_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic             wm_q, wm_d;
    logic             wr_q, wr_d;
    logic             mtr_q, mtr_d;
    logic             wf_q, wf_d;
    logic             awaiting, got_ack, finish;
    logic             is_mul, is_jmp, is_br, is_mem;

    // jump is redundant with the opcode decode of 0111
    logic unused_jump;
    assign unused_jump = jump;

    assign is_mul = (op_q == 4'b1111);
    assign is_jmp = (op_q == 4'b0111);
    assign is_br  = (op_q == 4'b1101) || (op_q == 4'b1110);
    assign is_mem = (op_q == 4'b1011) || (op_q == 4'b1100);

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        cnt_d     = cnt_q;
        awaiting  = 1'b0;
        got_ack   = 1'b0;
        finish    = 1'b0;
        imem_req  = 1'b0;
        ir_load   = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        mul_start = 1'b0;
        reg_we    = 1'b0;
        flag_we   = 1'b0;
        pc_load   = 1'b0;
        pc_sel    = 2'b00;
        fault     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                awaiting = 1'b1;
                got_ack  = imem_ack;
                if (imem_ack) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (is_mul) begin
                    // counter is zero only in the first EXEC cycle
                    mul_start = (wait_q == '0);
                    awaiting  = 1'b1;
                    got_ack   = mul_done;
                    if (mul_done) state_d = S_WB;
                end else if (is_jmp) begin
                    pc_load = 1'b1;
                    pc_sel  = 2'b10;
                    finish  = 1'b1;
                end else if (is_br) begin
                    pc_load = 1'b1;
                    pc_sel  = branch ? 2'b01 : 2'b00;
                    finish  = 1'b1;
                end else if (is_mem) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = wm_q;
                awaiting = 1'b1;
                got_ack  = dmem_ack;
                if (dmem_ack) begin
                    if (mtr_q) begin
                        state_d = S_WB;
                    end else begin
                        pc_load = 1'b1;
                        finish  = 1'b1;
                    end
                end
            end
            S_WB: begin
                reg_we  = wr_q;
                flag_we = wf_q;
                pc_load = 1'b1;
                finish  = 1'b1;
            end
            S_FAULT: fault = 1'b1;
            default: state_d = S_FAULT;
        endcase
        if (awaiting && !got_ack) begin
            if (wait_q == TO_LAST) state_d = S_FAULT;
            else                   wait_d  = wait_q + 1'b1;
        end
        if (finish) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = run ? S_FETCH : S_IDLE;
        end
    end

    always_comb begin
        op_d  = op_q;
        wm_d  = wm_q;
        wr_d  = wr_q;
        mtr_d = mtr_q;
        wf_d  = wf_q;
        if (state_q == S_DECODE) begin
            op_d  = OP;
            wm_d  = WriteMem;
            wr_d  = WriteReg;
            mtr_d = MemToReg;
            wf_d  = WrFlag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            wm_q    <= 1'b0;
            wr_q    <= 1'b0;
            mtr_q   <= 1'b0;
            wf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            wm_q    <= wm_d;
            wr_q    <= wr_d;
            mtr_q   <= mtr_d;
            wf_q    <= wf_d;
        end
    end

    assign busy      = (state_q != S_IDLE) && (state_q != S_FAULT);
    assign state     = state_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed steps plus randomized instructions
// checked against per-instruction expectations derived from phase rules.
module tb_instr_sequencer;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n, run;
    logic [3:0]    OP;
    logic          jump, branch, WriteMem, WriteReg, MemToReg, WrFlag;
    logic          imem_ack, dmem_ack, mul_done;
    logic          imem_req, ir_load, dmem_req, dmem_we, mul_start;
    logic          reg_we, flag_we, pc_load, busy, fault;
    logic [1:0]    pc_sel;
    logic [2:0]    state;
    logic [CW-1:0] instr_cnt;
    logic [11:0]   ctl;

    always #5 clk = ~clk;

    instr_sequencer #(.TIMEOUT(15), .TO_W(4), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .OP(OP),
        .jump(jump), .branch(branch), .WriteMem(WriteMem),
        .WriteReg(WriteReg), .MemToReg(MemToReg), .WrFlag(WrFlag),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .mul_done(mul_done),
        .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .mul_start(mul_start), .reg_we(reg_we),
        .flag_we(flag_we), .pc_load(pc_load), .pc_sel(pc_sel),
        .busy(busy), .fault(fault), .state(state), .instr_cnt(instr_cnt)
    );

    assign ctl = {imem_req, ir_load, dmem_req, dmem_we, mul_start,
                  reg_we, flag_we, pc_load, pc_sel, busy, fault};

    int checks = 0;
    int errors = 0;
    logic [CW-1:0] exp_cnt;

    int          r_lat, r_reg, r_flag, r_ms, r_dreq, r_dwe, r_irl, r_mulw;
    logic [1:0]  r_sel;
    logic        r_regpc, r_fault, r_done;
    logic [31:0] r_trace;
    logic [CW-1:0] r_cnt;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a posedge; returns just after the posedge
    // that ends the instruction (or after FAULT is seen).
    task automatic run_instr(input logic [3:0] op, input logic wm, wr,
                             mtr, wf, br, input int id, dd, md,
                             input bit drop_run);
        int fc, dc, mc;
        fc = 0; dc = 0; mc = 0;
        r_lat = 0; r_reg = 0; r_flag = 0; r_ms = 0; r_dreq = 0;
        r_dwe = 0; r_irl = 0; r_mulw = 0; r_sel = 2'b11;
        r_regpc = 1'b0; r_fault = 1'b0; r_done = 1'b0;
        r_trace = '0; r_cnt = '1;
        OP = op; WriteMem = wm; WriteReg = wr; MemToReg = mtr;
        WrFlag = wf; branch = br; jump = (op == 4'b0111);
        for (int cyc = 0; cyc < 100; cyc++) begin
            #1;
            imem_ack = imem_req && (fc + 1 == id);
            dmem_ack = dmem_req && (dc + 1 == dd);
            mul_done = (state == 3'd3) && (op == 4'hF) && (mc + 1 == md);
            #1;
            if (imem_req) fc++;
            if (dmem_req) begin
                dc++;
                if (drop_run) run = 1'b0;
            end
            if (state == 3'd3 && op == 4'hF) mc++;
            r_mulw = mc;
            if (busy) begin
                r_lat++;
                r_trace = {r_trace[27:0], 1'b0, state};
            end
            r_reg  += int'(reg_we);
            r_flag += int'(flag_we);
            r_ms   += int'(mul_start);
            r_dreq += int'(dmem_req);
            r_dwe  += int'(dmem_req && dmem_we);
            r_irl  += int'(ir_load);
            if (fault) r_fault = 1'b1;
            if (pc_load) begin
                r_sel   = pc_sel;
                r_regpc = reg_we;
                r_cnt   = instr_cnt;
                r_done  = 1'b1;
            end
            @(posedge clk);
            if (r_done || r_fault) break;
        end
    endtask

    // Expected per-instruction behaviour from the phase rules.
    task automatic check_model(input logic [3:0] op, input logic wm, wr,
                               mtr, wf, br, input int id, dd, md);
        bit is_j, is_b, is_m, is_mem, wb;
        int lat, sel;
        is_j   = (op == 4'h7);
        is_b   = (op == 4'hD) || (op == 4'hE);
        is_m   = (op == 4'hF);
        is_mem = (op == 4'hB) || (op == 4'hC);
        sel = 0;
        if (is_j) begin
            lat = 3; wb = 0; sel = 2;
        end else if (is_b) begin
            lat = 3; wb = 0; sel = int'(br);
        end else if (is_m) begin
            lat = 3 + md; wb = 1;
        end else if (is_mem) begin
            lat = 3 + dd + int'(mtr); wb = mtr;
        end else begin
            lat = 4; wb = 1;
        end
        lat += id - 1;
        chk("done", r_done, 1);
        chk("latency", r_lat, lat);
        chk("pc_sel", r_sel, sel);
        chk("reg_we_cnt", r_reg, wb ? int'(wr) : 0);
        chk("flag_we_cnt", r_flag, wb ? int'(wf) : 0);
        chk("mul_start_cnt", r_ms, int'(is_m));
        chk("dmem_req_cnt", r_dreq, is_mem ? dd : 0);
        chk("dmem_we_cnt", r_dwe, (is_mem && wm) ? dd : 0);
        chk("ir_load_cnt", r_irl, 1);
        chk("instr_cnt", r_cnt, exp_cnt);
        exp_cnt++;
    endtask

    task automatic step(input logic [3:0] op, input logic wm, wr, mtr,
                        wf, br, input int id, dd, md);
        run_instr(op, wm, wr, mtr, wf, br, id, dd, md, 1'b0);
        check_model(op, wm, wr, mtr, wf, br, id, dd, md);
    endtask

    initial begin
        logic [3:0] rop;
        logic [4:0] rb;
        int rid, rdd, rmd;
        rst_n = 1'b0; run = 1'b0; OP = '0; jump = 0; branch = 0;
        WriteMem = 0; WriteReg = 0; MemToReg = 0; WrFlag = 0;
        imem_ack = 0; dmem_ack = 0; mul_done = 0;
        exp_cnt = '0;
        #2;
        chk("reset_ctl", ctl, 12'h0);
        chk("reset_state", state, 3'd0);
        chk("reset_cnt", instr_cnt, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1; run = 1'b1;
        @(posedge clk);

        run_instr(4'h2, 0, 1, 0, 1, 0, 1, 1, 1, 1'b0);
        check_model(4'h2, 0, 1, 0, 1, 0, 1, 1, 1);
        chk("add_trace", r_trace, 32'h1235);
        chk("add_wb_regpc", r_regpc, 1);

        step(4'hB, 0, 1, 1, 0, 0, 1, 3, 1);
        step(4'hC, 1, 0, 0, 0, 0, 1, 1, 1);
        step(4'hD, 0, 0, 0, 0, 1, 1, 1, 1);
        step(4'hD, 0, 1, 0, 0, 0, 1, 1, 1);
        step(4'hE, 0, 1, 0, 1, 1, 1, 1, 1);
        step(4'h7, 0, 1, 0, 0, 0, 1, 1, 1);
        step(4'hF, 0, 1, 0, 1, 0, 1, 1, 5);
        step(4'hF, 0, 0, 0, 1, 0, 1, 1, 1);
        step(4'h2, 0, 1, 0, 0, 0, 15, 1, 1);
        step(4'hC, 1, 0, 0, 0, 0, 1, 15, 1);
        step(4'h0, 1, 1, 0, 1, 0, 2, 1, 1);

        run_instr(4'hB, 0, 1, 1, 0, 0, 1, 2, 1, 1'b1);
        check_model(4'hB, 0, 1, 1, 0, 0, 1, 2, 1);
        #2;
        chk("norun_state", state, 3'd0);
        chk("norun_busy", busy, 0);
        @(posedge clk);
        #2;
        chk("norun_stay", state, 3'd0);
        run = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_fetch_ctl", ctl, 12'h0);
        chk("rst_fetch_state", state, 3'd0);
        chk("rst_fetch_cnt", instr_cnt, 0);
        exp_cnt = '0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);

        run_instr(4'hF, 0, 1, 0, 1, 0, 1, 1, 0, 1'b0);
        chk("multo_fault", r_fault, 1);
        chk("multo_done", r_done, 0);
        chk("multo_waits", r_mulw, 15);
        chk("multo_start", r_ms, 1);
        #2;
        chk("fault_state", state, 3'd7);
        chk("fault_ctl", ctl, 12'h001);
        imem_ack = 1; dmem_ack = 1; mul_done = 1;
        repeat (5) @(posedge clk);
        #2;
        chk("fault_sticky", state, 3'd7);
        chk("fault_sticky_ctl", ctl, 12'h001);
        rst_n = 1'b0;
        imem_ack = 0; dmem_ack = 0; mul_done = 0;
        #1;
        chk("fault_rst_ctl", ctl, 12'h0);
        chk("fault_rst_state", state, 3'd0);
        exp_cnt = '0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);

        for (int i = 0; i < 2**CW + 1; i++)
            step(4'h7, 0, 0, 0, 0, 0, 1, 1, 1);
        chk("cnt_wrap", r_cnt, 0);

        for (int i = 0; i < 300; i++) begin
            rop = 4'($urandom_range(0, 15));
            rb  = 5'($urandom);
            rid = $urandom_range(1, 4);
            rdd = $urandom_range(1, 4);
            rmd = $urandom_range(1, 6);
            step(rop, rb[0], rb[1], rb[2], rb[3], rb[4], rid, rdd, rmd);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle instruction sequencer that drives the CPU datapath through the FETCH, DECODE, EXEC, MEM and WB phases around the combinational control unit. It consumes the control unit's decoded signals and the 4-bit opcode, and handshakes with instruction memory, data memory and the multi-cycle multiplier. It issues one-cycle register, flag and PC strobes, and enters a sticky fault state when a handshake times out.

## Interface
- TIMEOUT, 15: maximum wait cycles for any ack/done before fault (1..2^TO_W-1)
- TO_W, 4: width of wait counter
- CNT_W, 16: width of retired-instruction counter
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = keep issuing instructions
- OP  in  4  opcode from instruction register
- jump, branch  in  1 each  from control unit (branch already qualified by zero)
- WriteMem, WriteReg, MemToReg, WrFlag  in  1 each  from control unit
- imem_ack  in  1  instruction word valid
- dmem_ack  in  1  data access complete
- mul_done  in  1  multiplier result valid
- imem_req  out  1  instruction fetch request
- ir_load  out  1  load instruction register
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write qualifier (valid with dmem_req)
- mul_start  out  1  one-cycle multiplier start pulse
- reg_we  out  1  register file write strobe
- flag_we  out  1  flag register write strobe
- pc_load  out  1  PC update strobe
- pc_sel  out  2  00 = PC+1, 01 = branch target, 10 = jump target
- busy  out  1  state not IDLE and not FAULT
- fault  out  1  sticky timeout indication
- state  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7
- instr_cnt  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

## Operation
- Registers: state, wait counter, instr_cnt, and the latched controls OPq, WMq, WRq, MTRq, WFq. All outputs are combinational decodes of state, latched controls and current inputs.
- IDLE: if run = 1, go to FETCH.
- FETCH: imem_req = 1. On imem_ack, ir_load = 1 and go to DECODE.
- DECODE: one cycle. Latch OP, WriteMem, WriteReg, MemToReg and WrFlag. Go to EXEC.
- EXEC, OPq = 1111 (mul): mul_start = 1 in the first EXEC cycle only. Wait for mul_done, then go to WB.
- EXEC, OPq = 0111: pc_load = 1, pc_sel = 10. The instruction finishes here.
- EXEC, OPq = 1101/1110: pc_load = 1, pc_sel = 01 if branch = 1, else 00. The instruction finishes here. reg_we is never asserted for these opcodes, regardless of WriteReg.
- EXEC, OPq = 1011/1100: go to MEM.
- EXEC, all other opcodes: go to WB after one cycle.
- MEM: dmem_req = 1, dmem_we = WMq. On dmem_ack:
  - MTRq = 1: go to WB.
  - MTRq = 0: pc_load = 1, pc_sel = 00, and the instruction finishes.
- WB: one cycle. reg_we = WRq, flag_we = WFq, pc_load = 1, pc_sel = 00. The instruction finishes.
- Finish: instr_cnt increments on the pc_load cycle. Next state is FETCH if run = 1 in that cycle, else IDLE.
- run only affects the next-instruction decision. Deasserting run mid-instruction never aborts the instruction in flight.
- Timeout: the wait counter clears on entry to FETCH, EXEC(mul) and MEM, and increments each cycle the awaited input is 0.
  - If the counter equals TIMEOUT-1 and the input is still 0, go to FAULT. An ack is therefore accepted in wait cycles 1..TIMEOUT.
- FAULT: fault = 1. All other outputs are 0 except state and instr_cnt. FAULT is left only by reset.
- Unused state encoding 6: next state FAULT.
- Ack/done inputs arriving outside their wait state are ignored.

## Timing
- Reset (asynchronous, any time, including mid-handshake):
  - state = IDLE and every output = 0: imem_req, ir_load, dmem_req, dmem_we, mul_start, reg_we, flag_we, pc_load, pc_sel = 00, busy, fault, instr_cnt = 0.
  - Latched controls and wait counter are cleared.
- Latency with acks in the first wait cycle, measured from entering FETCH to the pc_load cycle inclusive:
  - ALU/immediate ops: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - jmp/beq/bne: 3 cycles.
  - mul: 4 + (cycles until mul_done) − 1.
- Exactly one pc_load per instruction. At most one of reg_we and pc_load-from-EXEC occurs per cycle.
- ir_load is coincident with the accepted imem_ack cycle. mul_start is never asserted for more than one cycle per mul.
- Back-to-back: FETCH of the next instruction begins the cycle after pc_load.

## Test plan
- Reset, run = 1, add (OP 0010, WriteReg = 1, WrFlag = 1), acks immediate -> states 1,2,3,5. In the WB cycle: reg_we = 1, flag_we = 1, pc_load = 1, pc_sel = 00. instr_cnt = 1.
- lw (1011, MTR = 1) with dmem_ack delayed 3 cycles -> MEM for 3 cycles with dmem_req = 1 and dmem_we = 0, then WB with reg_we = 1. sw (1100) -> dmem_we = 1, pc_load in the ack cycle, reg_we never asserted.
- beq (1101) with branch = 1 -> pc_sel = 01 in EXEC. beq with branch = 0 and WriteReg = 1 -> pc_sel = 00 and reg_we = 0. jmp (0111) -> pc_sel = 10.
- mul (1111), mul_done after 5 cycles -> mul_start high for exactly 1 cycle, then WB with flag_we = 1. With mul_done withheld -> FAULT after 15 wait cycles, fault = 1, busy = 0, sticky until rst_n.
- Deassert run during MEM -> the instruction completes, then state = IDLE and busy = 0. Assert rst_n = 0 mid-FETCH -> all outputs 0 immediately.
- Preload instr_cnt to 0xFFFF via 65535 jmp instructions, then one more -> instr_cnt wraps to 0.
